// File: rtl/spi_rx_deserializer.sv
// SPI mode-0 receive stage: synchronizes cs/sclk/data, deserializes MSB-first
// frames and hands words out through a 2-entry ready/valid buffer.
module spi_rx_deserializer #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      spi_cs_l,
   input  logic                      spi_sclk,
   input  logic                      spi_data,
   output logic [DATA_W-1:0]         rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic [$clog2(DATA_W):0]   rx_bitcnt,
   output logic                      frame_err,
   output logic                      overrun,
   output logic [15:0]               frame_cnt
);

   localparam int CW = $clog2(DATA_W) + 1;

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   logic w_cs, w_sclk, w_data, w_hi;

   // w_hi mirrors cs but resets low, so cs only arms once truly seen high
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_cs   = spi_cs_l;
         assign w_sclk = spi_sclk;
         assign w_data = spi_data;
         assign w_hi   = spi_cs_l;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_cs_s, r_sclk_s, r_data_s, r_hi_s;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cs_s   <= '1;
               r_sclk_s <= '0;
               r_data_s <= '0;
               r_hi_s   <= '0;
            end else begin
               r_cs_s[0]   <= spi_cs_l;
               r_sclk_s[0] <= spi_sclk;
               r_data_s[0] <= spi_data;
               r_hi_s[0]   <= spi_cs_l;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  r_cs_s[i]   <= r_cs_s[i-1];
                  r_sclk_s[i] <= r_sclk_s[i-1];
                  r_data_s[i] <= r_data_s[i-1];
                  r_hi_s[i]   <= r_hi_s[i-1];
               end
            end
         end
         assign w_cs   = r_cs_s[SYNC_STAGES-1];
         assign w_sclk = r_sclk_s[SYNC_STAGES-1];
         assign w_data = r_data_s[SYNC_STAGES-1];
         assign w_hi   = r_hi_s[SYNC_STAGES-1];
      end
   endgenerate

   logic r_cs_q, r_sclk_q, r_armed;
   logic r_cs_fall, r_cs_rise, r_sclk_rise, r_data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cs_q      <= 1'b1;
         r_sclk_q    <= 1'b0;
         r_armed     <= 1'b0;
         r_cs_fall   <= 1'b0;
         r_cs_rise   <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_data_q    <= 1'b0;
      end else begin
         r_cs_q      <= w_cs;
         r_sclk_q    <= w_sclk;
         r_armed     <= r_armed | w_hi;
         r_cs_fall   <= r_cs_q & ~w_cs & r_armed;
         r_cs_rise   <= ~r_cs_q & w_cs;
         r_sclk_rise <= ~r_sclk_q & w_sclk;
         r_data_q    <= w_data;
      end
   end

   state_t            r_state, w_state_nx;
   logic [DATA_W-1:0] r_shreg, w_shreg_nx;
   logic [CW-1:0]     r_bitcnt, w_bitcnt_nx;
   logic              w_push, w_err;

   always_comb begin
      w_state_nx  = r_state;
      w_shreg_nx  = r_shreg;
      w_bitcnt_nx = r_bitcnt;
      w_push      = 1'b0;
      w_err       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (r_cs_fall) begin
               w_state_nx  = S_SHIFT;
               w_shreg_nx  = '0;
               w_bitcnt_nx = '0;
            end
         end
         S_SHIFT: begin
            if (r_cs_rise) begin
               w_state_nx = S_IDLE;
               if (r_bitcnt == CW'(DATA_W)) w_push = 1'b1;
               else                         w_err  = 1'b1;
            end else if (r_sclk_rise) begin
               if (r_bitcnt < CW'(DATA_W)) begin
                  w_shreg_nx  = {r_shreg[DATA_W-2:0], r_data_q};
                  w_bitcnt_nx = r_bitcnt + 1'b1;
               end else begin
                  w_bitcnt_nx = CW'(DATA_W + 1);
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wr_ptr, r_rd_ptr;
   logic [1:0]        r_count;
   logic              r_frame_err, r_overrun;
   logic [15:0]       r_frame_cnt;
   logic              w_pop, w_full, w_wr;

   assign w_pop  = (r_count != 2'd0) & rx_ready;
   assign w_full = (r_count == 2'd2);
   assign w_wr   = w_push & (~w_full | w_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_shreg     <= '0;
         r_bitcnt    <= '0;
         r_mem[0]    <= '0;
         r_mem[1]    <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_shreg     <= w_shreg_nx;
         r_bitcnt    <= w_bitcnt_nx;
         if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shreg;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count     <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
         r_frame_err <= w_err;
         r_overrun   <= w_push & w_full & ~w_pop;
         r_frame_cnt <= r_frame_cnt + {15'd0, w_push};
      end
   end

   assign rx_data   = r_mem[r_rd_ptr];
   assign rx_valid  = (r_count != 2'd0);
   assign rx_bitcnt = r_bitcnt;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Scoreboard bench for spi_rx_deserializer: directed SPI frames, expected
// words queued at issue time and popped by an independent handshake monitor.
module tb_spi_rx_deserializer;

   logic        clk = 1'b0;
   logic        reset_n, cs, sclk, sdata, ready;
   logic [15:0] rx_data;
   logic        rx_valid, frame_err, overrun;
   logic [4:0]  rx_bitcnt;
   logic [15:0] frame_cnt;

   spi_rx_deserializer #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .spi_cs_l(cs), .spi_sclk(sclk), .spi_data(sdata),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(ready),
      .rx_bitcnt(rx_bitcnt), .frame_err(frame_err),
      .overrun(overrun), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int n_err = 0, n_ovr = 0, n_hs = 0;
   logic [15:0] exp_q[$];
   logic [15:0] prev_data = '0;
   logic        prev_hold = 1'b0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // monitor: inputs change at posedge+2, so negedge sees handshake values
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_hold = 1'b0;
      end else begin
         if (frame_err) n_err++;
         if (overrun) n_ovr++;
         if (prev_hold) chk("hold_stable", {rx_valid, rx_data}, {1'b1, prev_data});
         if (rx_valid && ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got %h expected none", rx_data);
            end else begin
               chk("rx_data", rx_data, exp_q.pop_front());
            end
            n_hs++;
         end
         prev_hold = rx_valid && !ready;
         prev_data = rx_data;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic cs_low();
      cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      tick(3);
      cs = 1'b1;
   endtask

   task automatic shift_bits(input logic [16:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         sdata = b[n-1-i];
         tick(3);
         sclk = 1'b1;
         tick(3);
         sclk = 1'b0;
      end
   endtask

   task automatic send(input logic [15:0] w, input bit expect_push);
      if (expect_push) exp_q.push_back(w);
      cs_low();
      shift_bits({1'b0, w}, 16);
      cs_high();
      tick(8);
   endtask

   task automatic drain(input string nm);
      int k = 0;
      ready = 1'b1;
      while (exp_q.size() != 0 && k < 200) begin
         tick(1);
         k++;
      end
      chk(nm, exp_q.size(), 0);
      tick(3);
   endtask

   int e0, h0, o0;

   initial begin
      reset_n = 1'b0;
      cs = 1'b1; sclk = 1'b0; sdata = 1'b0; ready = 1'b0;
      tick(3);
      chk("reset_outputs",
          {rx_valid, rx_data, rx_bitcnt, frame_err, overrun, frame_cnt},
          {1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 16'h0});
      reset_n = 1'b1;
      tick(4);

      // 1: three good frames, consumer always ready
      ready = 1'b1;
      send(16'h0412, 1);
      send(16'h4839, 1);
      send(16'hABEB, 1);
      chk("t1_frame_cnt", frame_cnt, 3);
      chk("t1_handshakes", n_hs, 3);
      chk("t1_no_err_ovr", n_err + n_ovr, 0);
      chk("t1_bitcnt", rx_bitcnt, 16);

      // 2: short frame
      e0 = n_err; h0 = n_hs;
      cs_low();
      shift_bits(17'h000A5, 8);
      cs_high();
      tick(8);
      chk("t2_err_pulse", n_err - e0, 1);
      chk("t2_no_word", {rx_valid, 8'(n_hs - h0)}, 9'd0);
      chk("t2_frame_cnt", frame_cnt, 3);

      // 3: 17-bit frame
      e0 = n_err; h0 = n_hs;
      cs_low();
      shift_bits({16'hABEB, 1'b1}, 17);
      cs_high();
      tick(8);
      chk("t3_err_pulse", n_err - e0, 1);
      chk("t3_bitcnt", rx_bitcnt, 17);
      chk("t3_no_push", {frame_cnt, 8'(n_hs - h0)}, {16'd3, 8'd0});

      // 4: consumer stalled, third frame overruns
      ready = 1'b0;
      o0 = n_ovr;
      send(16'h1111, 1);
      send(16'h2222, 1);
      chk("t4_no_ovr_yet", n_ovr - o0, 0);
      send(16'h3333, 0);
      chk("t4_overrun", n_ovr - o0, 1);
      chk("t4_frame_cnt", frame_cnt, 6);
      chk("t4_head", {rx_valid, rx_data}, {1'b1, 16'h1111});
      drain("t4_drain");
      chk("t4_empty", rx_valid, 0);

      // 5: push and pop collide while full
      ready = 1'b0;
      o0 = n_ovr;
      send(16'h1111, 1);
      send(16'h2222, 1);
      exp_q.push_back(16'h4444);
      cs_low();
      shift_bits({1'b0, 16'h4444}, 16);
      cs_high();
      tick(3);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(4);
      chk("t5_no_overrun", n_ovr - o0, 0);
      chk("t5_frame_cnt", frame_cnt, 9);
      chk("t5_head", {rx_valid, rx_data}, {1'b1, 16'h2222});
      drain("t5_drain");
      chk("t5_empty", rx_valid, 0);

      // 6: async reset mid-frame, released with cs still low
      ready = 1'b1;
      cs_low();
      shift_bits({1'b0, 16'h0412} >> 9, 7);
      reset_n = 1'b0;
      tick(2);
      chk("t6_reset_clear",
          {rx_valid, rx_bitcnt, frame_cnt}, {1'b0, 5'd0, 16'd0});
      reset_n = 1'b1;
      e0 = n_err; h0 = n_hs;
      tick(4);
      shift_bits(17'h000FF, 8);
      chk("t6_no_capture", rx_bitcnt, 0);
      cs_high();
      tick(8);
      chk("t6_quiet", {8'(n_err - e0), 8'(n_hs - h0), rx_valid}, 17'd0);
      send(16'h4839, 1);
      chk("t6_rx_ok", {frame_cnt, 8'(n_hs - h0)}, {16'd1, 8'd1});
      chk("t6_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
